// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op encodings, FSM states and helpers for the multiply/divide unit
// Imported by mult_div_unit and mdu_divider.
package mdu_pkg;

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5,
      OP_NOP6  = 3'd6,
      OP_NOP7  = 3'd7
   } mdu_op_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CALC   = 2'd1,
      ST_FINISH = 2'd2
   } mdu_state_t;

   function automatic logic op_is_signed(mdu_op_t o);
      return (o == OP_MULT) || (o == OP_DIV);
   endfunction

   function automatic logic op_is_mul(mdu_op_t o);
      return (o == OP_MULT) || (o == OP_MULTU);
   endfunction

endpackage

// File: rtl/mdu_divider.sv
// rtl/mdu_divider.sv - restoring divider, one quotient bit per step, with sign handling
// Works on magnitudes; quotient/remainder signs are applied on the way out.
module mdu_divider
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic             step_i,
   input  logic             signed_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] quot_o,
   output logic [WIDTH-1:0] rem_o
);

   logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
   logic             qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
   logic             a_neg, b_neg, ge;
   logic [WIDTH:0]   rshift;
   logic [WIDTH-1:0] sub;

   assign a_neg  = signed_i & a_i[WIDTH-1];
   assign b_neg  = signed_i & b_i[WIDTH-1];
   assign rshift = {rem_q, quo_q[WIDTH-1]};
   assign ge     = rshift >= {1'b0, dvs_q};
   // when ge holds the true difference is below the divisor, so the low bits suffice
   assign sub    = rshift[WIDTH-1:0] - dvs_q;

   always_comb begin
      quo_d  = quo_q;
      rem_d  = rem_q;
      dvs_d  = dvs_q;
      qneg_d = qneg_q;
      rneg_d = rneg_q;
      dz_d   = dz_q;
      if (load_i) begin
         quo_d  = a_neg ? -a_i : a_i;
         rem_d  = '0;
         dvs_d  = b_neg ? -b_i : b_i;
         qneg_d = a_neg ^ b_neg;
         rneg_d = a_neg;
         dz_d   = (b_i == '0);
      end else if (step_i) begin
         if (ge) begin
            rem_d = sub;
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
         end else begin
            rem_d = rshift[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         quo_q  <= '0;
         rem_q  <= '0;
         dvs_q  <= '0;
         qneg_q <= 1'b0;
         rneg_q <= 1'b0;
         dz_q   <= 1'b0;
      end else begin
         quo_q  <= quo_d;
         rem_q  <= rem_d;
         dvs_q  <= dvs_d;
         qneg_q <= qneg_d;
         rneg_q <= rneg_d;
         dz_q   <= dz_d;
      end
   end

   // a zero divisor leaves |a| in the remainder, which the sign fixup turns back into a
   assign quot_o = dz_q ? '1 : (qneg_q ? -quo_q : quo_q);
   assign rem_o  = rneg_q ? -rem_q : rem_q;

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative HI/LO multiply/divide unit with MTHI/MTLO and abort
// Defining MDU_FAST_MUL_EN swaps the shift-add multiplier for a single-cycle array multiply.
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             sysclk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             abort,
   input  logic             read_req,
   output logic             busy,
   output logic             done,
   output logic             stall_req,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   mdu_state_t         state_q, state_d;
   mdu_op_t            op_q, op_d, op_in;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d, hi_q, hi_d, lo_q, lo_d;
   logic [2*WIDTH-1:0] prod_q, prod_d, prod_fin, mul_res;
   logic               mneg_q, mneg_d;
   logic [WIDTH:0]     add_sum;
   logic [WIDTH-1:0]   a_mag, b_mag, quot, rem, res_hi, res_lo;
   logic               sgn_in, div_load, div_step;

   assign op_in   = mdu_op_t'(op);
   assign sgn_in  = op_is_signed(op_in);
   assign a_mag   = (sgn_in && a[WIDTH-1]) ? -a : a;
   assign b_mag   = (sgn_in && b[WIDTH-1]) ? -b : b;
   assign add_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};

`ifdef MDU_FAST_MUL_EN
   assign prod_fin = {{WIDTH{1'b0}}, mcand_q} * {{WIDTH{1'b0}}, prod_q[WIDTH-1:0]};
`else
   assign prod_fin = prod_q;
`endif
   assign mul_res = mneg_q ? -prod_fin : prod_fin;
   assign res_hi  = op_is_mul(op_q) ? mul_res[2*WIDTH-1:WIDTH] : rem;
   assign res_lo  = op_is_mul(op_q) ? mul_res[WIDTH-1:0] : quot;

   mdu_divider #(.WIDTH(WIDTH)) u_div (
      .clk_i    (sysclk),
      .rst_ni   (rst),
      .load_i   (div_load),
      .step_i   (div_step),
      .signed_i (sgn_in),
      .a_i      (a),
      .b_i      (b),
      .quot_o   (quot),
      .rem_o    (rem)
   );

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      prod_d   = prod_q;
      mneg_d   = mneg_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      div_load = 1'b0;
      div_step = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start && !abort) begin
               unique case (op_in)
                  OP_MULT, OP_MULTU: begin
                     op_d    = op_in;
                     mcand_d = a_mag;
                     prod_d  = {{WIDTH{1'b0}}, b_mag};
                     mneg_d  = sgn_in & (a[WIDTH-1] ^ b[WIDTH-1]);
                     cnt_d   = CNT_W'(WIDTH - 1);
`ifdef MDU_FAST_MUL_EN
                     state_d = ST_FINISH;
`else
                     state_d = ST_CALC;
`endif
                  end
                  OP_DIV, OP_DIVU: begin
                     op_d     = op_in;
                     div_load = 1'b1;
                     cnt_d    = CNT_W'(WIDTH - 1);
                     state_d  = ST_CALC;
                  end
                  OP_MTHI: hi_d = a;
                  OP_MTLO: lo_d = a;
                  default: ;
               endcase
            end
         end
         ST_CALC: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else begin
               if (op_is_mul(op_q)) begin
                  prod_d = prod_q[0] ? {add_sum, prod_q[WIDTH-1:1]}
                                     : {1'b0, prod_q[2*WIDTH-1:1]};
               end else begin
                  div_step = 1'b1;
               end
               if (cnt_q == '0) state_d = ST_FINISH;
               else             cnt_d   = cnt_q - CNT_W'(1);
            end
         end
         // the result is already final here, so a late abort still commits it
         ST_FINISH: begin
            hi_d    = res_hi;
            lo_d    = res_lo;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge sysclk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         op_q    <= OP_MULT;
         cnt_q   <= '0;
         mcand_q <= '0;
         prod_q  <= '0;
         mneg_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         mcand_q <= mcand_d;
         prod_q  <= prod_d;
         mneg_q  <= mneg_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign busy      = (state_q == ST_CALC);
   assign done      = (state_q == ST_FINISH);
   assign stall_req = busy & read_req;
   assign hi        = done ? res_hi : hi_q;
   assign lo        = done ? res_lo : lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit with directed vectors
module tb_mult_div_unit;
   import mdu_pkg::*;

   localparam int W = 32;
`ifdef MDU_FAST_MUL_EN
   localparam int MUL_LAT   = 1;
   localparam int MUL_STALL = 0;
`else
   localparam int MUL_LAT   = W + 1;
   localparam int MUL_STALL = W;
`endif
   localparam int DIV_LAT = W + 1;

   logic         sysclk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0, abort = 1'b0, read_req = 1'b0;
   logic [2:0]   op = 3'd0;
   logic [W-1:0] a = '0, b = '0;
   logic         busy, done, stall_req;
   logic [W-1:0] hi, lo;

   typedef struct {
      string        name;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      int           cyc;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc = 0;

   mult_div_unit #(.WIDTH(W)) dut (
      .sysclk    (sysclk),
      .rst       (rst),
      .start     (start),
      .op        (op),
      .a         (a),
      .b         (b),
      .abort     (abort),
      .read_req  (read_req),
      .busy      (busy),
      .done      (done),
      .stall_req (stall_req),
      .hi        (hi),
      .lo        (lo)
   );

   always #5 sysclk = ~sysclk;
   always @(posedge sysclk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // monitor: every done pulse must match the oldest outstanding expectation
   always @(negedge sysclk) begin
      exp_t e;
      if (done === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected done", done, 0);
         end else begin
            e = sb.pop_front();
            check({e.name, " done cycle"}, cyc, e.cyc);
            check({e.name, " hi"}, hi, e.hi);
            check({e.name, " lo"}, lo, e.lo);
            check({e.name, " busy at done"}, busy, 0);
         end
      end
   end

   task automatic issue(input string name, input logic [2:0] o, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input bit exp_done, input logic [W-1:0] ehi,
                        input logic [W-1:0] elo, input int lat);
      exp_t e;
      @(negedge sysclk);
      if (exp_done) begin
         e.name = name; e.hi = ehi; e.lo = elo; e.cyc = cyc + lat;
         sb.push_back(e);
      end
      start = 1'b1; op = o; a = av; b = bv;
      @(negedge sysclk);
      start = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((sb.size() != 0 || busy) && n < 200) begin
         @(negedge sysclk);
         n++;
      end
      check({name, " drain timeout"}, n < 200, 1);
      @(negedge sysclk);
   endtask

   initial begin
      int n, stalls;
      #1 rst = 1'b0;
      read_req = 1'b1;
      @(negedge sysclk);
      check("reset hi", hi, 0);
      check("reset lo", lo, 0);
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset stall_req", stall_req, 0);
      read_req = 1'b0;
      rst = 1'b1;

      issue("MULT -3*7", OP_MULT, 32'hFFFF_FFFD, 32'd7, 1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL_LAT);
      check("busy after MULT start", busy, MUL_LAT > 1);
      wait_drain("MULT");

      issue("DIV -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT);
      check("busy after DIV start", busy, 1);
      wait_drain("DIV");
      issue("DIVU 7/0", OP_DIVU, 32'd7, 32'd0, 1, 32'd7, 32'hFFFF_FFFF, DIV_LAT);
      wait_drain("DIVU0");
      issue("DIV min/-1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0, 32'h8000_0000, DIV_LAT);
      wait_drain("DIVMIN");

      read_req = 1'b1;
      issue("MULTU max*max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 32'd1, MUL_LAT);
      n = 0; stalls = 0;
      while (!done && n < 100) begin
         if (stall_req) stalls++;
         @(negedge sysclk);
         n++;
      end
      check("stall cycles", stalls, MUL_STALL);
      check("stall_req at done", stall_req, 0);
      read_req = 1'b0;
      wait_drain("MULTU");

      issue("MTHI", OP_MTHI, 32'h1234, 32'd0, 0, '0, '0, 0);
      check("MTHI hi", hi, 32'h1234);
      check("MTHI busy", busy, 0);
      issue("MTLO", OP_MTLO, 32'h5678, 32'd0, 0, '0, '0, 0);
      check("MTLO lo", lo, 32'h5678);

      @(negedge sysclk);
      start = 1'b1; abort = 1'b1; op = OP_MTHI; a = 32'hDEAD;
      @(negedge sysclk);
      start = 1'b0; abort = 1'b0;
      check("MTHI with abort discarded", hi, 32'h1234);

      issue("DIVU aborted", OP_DIVU, 32'd100, 32'd3, 0, '0, '0, 0);
      repeat (3) @(negedge sysclk);
      start = 1'b1; op = OP_DIVU; a = 32'd9; b = 32'd2;
      @(negedge sysclk);
      start = 1'b0;
      check("busy before abort", busy, 1);
      repeat (4) @(negedge sysclk);
      abort = 1'b1;
      @(negedge sysclk);
      abort = 1'b0;
      check("busy after abort", busy, 0);
      repeat (40) @(negedge sysclk);
      check("abort keeps hi", hi, 32'h1234);
      check("abort keeps lo", lo, 32'h5678);

      issue("op6", 3'd6, 32'hBEEF, 32'd1, 0, '0, '0, 0);
      check("op6 busy", busy, 0);
      check("op6 hi", hi, 32'h1234);

      issue("MULTU 3*4 finish-abort", OP_MULTU, 32'd3, 32'd4, 1, 32'd0, 32'd12, MUL_LAT);
      n = 0;
      while (!done && n < 100) begin
         @(negedge sysclk);
         n++;
      end
      check("finish-abort reached done", n < 100, 1);
      abort = 1'b1;
      @(negedge sysclk);
      abort = 1'b0;
      check("finish-abort lo kept", lo, 32'd12);
      check("finish-abort hi kept", hi, 32'd0);

      issue("DIVU reset", OP_DIVU, 32'd100, 32'd7, 0, '0, '0, 0);
      repeat (8) @(negedge sysclk);
      #2 rst = 1'b0;
      #1;
      check("async reset hi", hi, 0);
      check("async reset lo", lo, 0);
      check("async reset busy", busy, 0);
      check("async reset done", done, 0);
      @(negedge sysclk);
      begin
         exp_t e;
         e.name = "MULTU 2*3 after reset"; e.hi = '0; e.lo = 32'd6; e.cyc = cyc + MUL_LAT;
         sb.push_back(e);
      end
      rst = 1'b1; start = 1'b1; op = OP_MULTU; a = 32'd2; b = 32'd3;
      @(negedge sysclk);
      start = 1'b0;
      wait_drain("MULTU after reset");
      repeat (5) @(negedge sysclk);

      check("scoreboard empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and HI/LO width; legal values are even numbers 8..64.
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH)+1, iteration counter width.
REQ-003 SHALL have port sysclk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  launch request, qualified by op.
REQ-006 SHALL have port op  input  3  MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; 6 and 7 are no-ops.
REQ-007 SHALL have port a  input  WIDTH  operand A, the dividend or MTHI/MTLO data.
REQ-008 SHALL have port b  input  WIDTH  operand B, the divisor.
REQ-009 SHALL have port abort  input  1  pipeline flush; cancels any in-flight operation.
REQ-010 SHALL have port read_req  input  1  the ID stage holds MFHI/MFLO.
REQ-011 SHALL have port busy  output  1  an operation is in flight.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port stall_req  output  1  asserted as busy AND read_req, combinational.
REQ-014 SHALL have port hi  output  WIDTH  HI register.
REQ-015 SHALL have port lo  output  WIDTH  LO register.

Function
REQ-016 SHALL implement FSM states IDLE, CALC and FINISH.
REQ-017 SHALL move IDLE->CALC on start with op 0..3 and load a, b and counter=WIDTH-1, where signed ops latch magnitudes and the result sign.
REQ-018 SHALL in CALC perform one shift-add (multiply) or one restoring subtract-shift (divide) per cycle and decrement the counter.
REQ-019 SHALL move CALC->FINISH when the counter reaches 0.
REQ-020 SHALL in FINISH apply the sign fixup, write HI/LO, pulse done and return to IDLE.
REQ-021 SHALL deliver done exactly WIDTH+1 cycles after the edge that samples start; busy is high from the next edge until done is high, and busy and done are never high together.
REQ-022 SHALL place the 2*WIDTH product in {hi,lo} for multiply; for divide, lo=quotient and hi=remainder, with the remainder carrying the sign of the dividend.
REQ-023 SHALL on divide-by-zero produce lo=all ones and hi=a, with no exception.
REQ-024 SHALL on signed DIV of the most-negative value by -1 produce lo=the most-negative value and hi=0.
REQ-025 SHALL write a to HI (MTHI) or LO (MTLO) in one cycle when op 4/5 is started in IDLE, without asserting busy or done.
REQ-026 SHALL ignore start while busy, and ignore start with op 6/7.
REQ-027 SHALL on abort go to IDLE on the next edge from any state, leave HI/LO unchanged and suppress done.
REQ-028 SHALL let abort win over a simultaneous start; an MTHI/MTLO in the same cycle as abort is discarded.
REQ-029 SHALL let the FINISH write complete if abort arrives in the FINISH cycle itself, and an operation already completed is never undone.

Reset
REQ-030 SHALL on rst low force state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0 and operand registers=0 immediately, regardless of sysclk.
REQ-031 SHALL if reset occurs mid-operation discard the partial result, with no done pulse after release.
REQ-032 SHALL accept start on the first rising edge after rst is released.

Configuration
REQ-033 SHALL support macro MDU_FAST_MUL_EN.
REQ-034 SHALL when MDU_FAST_MUL_EN is defined compute multiplies with a single-cycle array multiplier: IDLE->FINISH, done 1 cycle after start, busy never asserted for multiplies.
REQ-035 SHALL when MDU_FAST_MUL_EN is undefined run multiplies iteratively under REQ-021; divide timing is identical in both builds.

Structure
REQ-036 SHALL keep the op encodings, the FSM state enum and the mdu_op_t typedef in shared package mdu_pkg.
REQ-037 SHALL implement the restoring divide datapath, with its magnitude/sign handling, in sub-module mdu_divider; the multiply path and FSM are in mult_div_unit.

Verification
REQ-038 SHALL cover: MULT a=-3, b=7 -> done at cycle 33, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-039 SHALL cover: DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=7.
REQ-040 SHALL cover: DIV a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
REQ-041 SHALL cover: MULTU 0xFFFFFFFF*0xFFFFFFFF with read_req held -> stall_req high for 32 cycles, then hi=0xFFFFFFFE, lo=1.
REQ-042 SHALL cover: abort at cycle 10 of a DIVU, and a second start at cycle 5 -> no done, hi/lo keep the prior MTHI/MTLO values 0x1234/0x5678.
REQ-043 SHALL cover: rst asserted low mid-CALC -> all outputs 0 asynchronously; a new MULTU 2*3 after release -> lo=6, hi=0.
